unified_memory: RTL

Parametrised unified memory for the next core generation: replaces the separate instruction and data memories with one word-organised RAM shared by NUM_PORTS request channels (Fetch on port 0, Memory stage on port 1, further ports for debug/DMA). Arbitration is round-robin or fixed-priority. Each access uses a valid/ready request handshake and returns a one-cycle response pulse after a configurable latency. Out-of-range accesses are flagged with an error.

---
 rtl/unified_memory_pkg.sv | 18 +
 rtl/unified_memory_if.sv | 25 ++
 rtl/unified_memory_rr_arbiter.sv | 53 +++++
 rtl/unified_memory.sv | 136 +++++++++++++
 4 files changed

// File: rtl/unified_memory_pkg.sv
// Shared types and constants for the unified instruction/data memory.
// Imported by the arbiter and the top-level memory.
package unified_memory_pkg;

    localparam int ARB_ROUND_ROBIN = 0;
    localparam int ARB_FIXED       = 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } memState_;

    // A one-port build still needs a 1-bit index to carry the owner.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/unified_memory_if.sv
// Request/response bundle between the requesters (Fetch, Memory stage,
// debug/DMA) and the unified memory.
interface unified_memory_if #(
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0]    reqValid;
    logic [NUM_PORTS-1:0]    reqReady;
    logic [NUM_PORTS-1:0]    reqWrite;
    logic [NUM_PORTS*32-1:0] reqAddress;
    logic [NUM_PORTS*32-1:0] reqWriteData;
    logic [NUM_PORTS*4-1:0]  reqByteEnable;
    logic [NUM_PORTS-1:0]    respValid;
    logic [31:0]             respData;
    logic                    respError;

    modport master (
        output reqValid, reqWrite, reqAddress, reqWriteData, reqByteEnable,
        input  reqReady, respValid, respData, respError
    );

    modport slave (
        input  reqValid, reqWrite, reqAddress, reqWriteData, reqByteEnable,
        output reqReady, respValid, respData, respError
    );
endinterface

// File: rtl/unified_memory_rr_arbiter.sv
// Request arbiter: round-robin starting after the last grant, or fixed
// priority (lowest index wins). Grant is combinational from requests.
module rr_arbiter
    import unified_memory_pkg::*;
#(
    parameter int  NUM_PORTS = 2,
    parameter int  ARB_MODE  = ARB_ROUND_ROBIN,
    localparam int IDX_W     = idx_width(NUM_PORTS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] requests,
    input  logic                 advance,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_index
);

    logic [IDX_W-1:0] lastGrant;
    logic [IDX_W-1:0] cand_idx;
    int               cand;
    logic             found;

    // Reset to the top index so port 0 is first in line after reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            lastGrant <= IDX_W'(NUM_PORTS - 1);
        end else if (advance) begin
            lastGrant <= grant_index;
        end
    end

    always_comb begin
        grant       = '0;
        grant_index = '0;
        found       = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            if (ARB_MODE == ARB_FIXED) begin
                cand = k - 1;
            end else begin
                cand = (int'(lastGrant) + k) % NUM_PORTS;
            end
            cand_idx = IDX_W'(cand);
            if (!found && requests[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_index     = cand_idx;
            end
        end
    end

endmodule

// File: rtl/unified_memory.sv
// Word-organised RAM shared by NUM_PORTS requesters (port 0 = Fetch,
// port 1 = Memory stage, higher ports debug/DMA); one access in flight.
//
//   state | meaning
//   IDLE  | arbiter offers reqReady to one requester; accept starts access
//   BUSY  | access done, counting down LATENCY; respValid when counter is 0
module unified_memory
    import unified_memory_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1,
    parameter int ARB_MODE    = ARB_ROUND_ROBIN
) (
    input  logic              clock,
    input  logic              reset,
    unified_memory_if.slave   bus
);

    localparam int IDX_W = idx_width(NUM_PORTS);
    localparam int AW    = $clog2(DEPTH_WORDS);

    memState_               state;
    logic [IDX_W-1:0]       owner;
    logic [3:0]             counter;
    logic [NUM_PORTS-1:0]   grant;
    logic [IDX_W-1:0]       grant_index;
    logic                   accept;

    logic                   sel_write;
    logic [31:0]            sel_addr;
    logic [31:0]            sel_wdata;
    logic [3:0]             sel_be;
    logic [31:0]            word_addr;
    logic                   in_range;
    logic [AW-1:0]          word_index;

    logic [31:0]            mem [DEPTH_WORDS];

    logic [NUM_PORTS-1:0]   resp_valid_q;
    logic [31:0]            resp_data_q;
    logic                   resp_error_q;
    logic [NUM_PORTS-1:0]   owner_onehot;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .ARB_MODE  (ARB_MODE)
    ) u_arbiter (
        .clock       (clock),
        .reset       (reset),
        .requests    (bus.reqValid),
        .advance     (accept),
        .grant       (grant),
        .grant_index (grant_index)
    );

    // Held low during reset so nothing can be accepted while reset is applied.
    assign bus.reqReady = (state == IDLE && reset) ? grant : '0;
    assign accept       = |(bus.reqValid & bus.reqReady);

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_index == IDX_W'(i)) begin
                sel_write = bus.reqWrite[i];
                sel_addr  = bus.reqAddress[32*i +: 32];
                sel_wdata = bus.reqWriteData[32*i +: 32];
                sel_be    = bus.reqByteEnable[4*i +: 4];
            end
        end
    end

    // Byte offset bits are dropped; the range check uses the full word address.
    assign word_addr  = {2'b00, sel_addr[31:2]};
    assign in_range   = (word_addr < 32'(DEPTH_WORDS));
    assign word_index = word_addr[AW-1:0];

    always_ff @(posedge clock) begin
        if (accept && sel_write && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_be[b]) begin
                    mem[word_index][8*b +: 8] <= sel_wdata[8*b +: 8];
                end
            end
        end
    end

    assign owner_onehot = NUM_PORTS'(1) << owner;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            owner        <= '0;
            counter      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid_q <= '0;
                    if (accept) begin
                        owner        <= grant_index;
                        counter      <= 4'(LATENCY - 1);
                        state        <= BUSY;
                        resp_data_q  <= (!sel_write && in_range) ? mem[word_index] : '0;
                        resp_error_q <= !in_range;
                        if (LATENCY == 1) begin
                            resp_valid_q <= grant;
                        end
                    end
                end
                BUSY: begin
                    if (counter == 4'd0) begin
                        state        <= IDLE;
                        resp_valid_q <= '0;
                    end else begin
                        counter <= counter - 4'd1;
                        if (counter == 4'd1) begin
                            resp_valid_q <= owner_onehot;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.respValid = resp_valid_q;
    assign bus.respData  = resp_data_q;
    assign bus.respError = resp_error_q;

endmodule
